ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
- AHB-Lite responder: the slave-side end of the address decode path.
- Receives HSEL from the system decoder and services single and back-to-back transfers into a word-organised register-file memory.
- Supports programmable wait states, byte/halfword/word writes, and a two-cycle ERROR response for illegal accesses.
- Sits behind the decoder, one instance per slave slot; its HREADYOUT/HRESP/HRDATA feed the response mux.

Parameters:
- ADDR_W, 32, HADDR width.
- DATA_W, 32, data bus width; only 32 is supported.
- MEM_DEPTH, 256, number of 32-bit words; must be a power of two.
- WAIT_STATES, 0, wait cycles inserted per OKAY transfer, range 0..15.

Ports:
- HCLK  input  1  clock; all logic on its rising edge.
- HRESET  input  1  synchronous reset, active-high.
- HSEL  input  1  slave select from the decoder.
- HADDR  input  ADDR_W  address-phase address; the byte offset within the slot is HADDR[log2(MEM_DEPTH)+1:0].
- HTRANS  input  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  input  1  1 = write.
- HSIZE  input  3  transfer size: 0=byte, 1=half, 2=word, others illegal.
- HWDATA  input  DATA_W  write data, valid in the data phase.
- HREADY  input  1  bus-wide ready, from the response mux.
- HREADYOUT  output  1  this slave's ready.
- HRESP  output  1  0=OKAY, 1=ERROR.
- HRDATA  output  DATA_W  read data.

Behaviour:
- Accept condition: a transfer is accepted on a rising edge where HSEL & HREADY & HTRANS[1].
  - On accept, register HADDR, HWRITE and HSIZE, plus an illegal flag, into the data-phase registers.
  - IDLE/BUSY, or HSEL=0 with HREADY=1, means no data phase follows, and the slave responds zero-wait OKAY.
- Illegal access is any one of:
  - HSIZE > 2;
  - misalignment: half with HADDR[0]=1, or word with HADDR[1:0]≠0;
  - word index ≥ MEM_DEPTH, where the index is HADDR >> 2 masked to the slot offset width plus one bit.
- FSM states:
  - IDLE: no data phase; HREADYOUT=1, HRESP=0.
  - WAIT: HREADYOUT=0, HRESP=0. A 4-bit counter loads WAIT_STATES on accept and decrements each cycle; at count 1 the FSM moves to LAST.
  - LAST: HREADYOUT=1, HRESP=0; the transfer completes on this edge.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Transitions:
  - From IDLE or LAST, on accept: illegal → ERR1; WAIT_STATES=0 → LAST; otherwise → WAIT.
  - From IDLE or LAST with no accept → IDLE.
  - WAIT → LAST when the counter expires.
  - ERR1 → ERR2 unconditionally.
  - ERR2 evaluates accept exactly as IDLE does, so a pipelined transfer presented during ERR2 is honoured.
- Latency: a legal transfer completes WAIT_STATES+1 cycles after its address phase. An illegal one takes 2 cycles.
- Writes:
  - The memory updates on the LAST-state edge, using HWDATA and byte strobes derived from the registered HSIZE and HADDR[1:0] (little-endian lanes).
  - No memory update in ERR1/ERR2.
- Reads:
  - In WAIT/LAST of a read, HRDATA = mem[registered index], combinational from the array.
  - In every other state HRDATA=0.
  - A read issued immediately after a write to the same word returns the new data.
- Accepts outside IDLE/LAST/ERR2 cannot occur, since HREADY=0 then; the slave ignores the address phase.
- Reset (HRESET=1 at an edge):
  - FSM goes to IDLE, the counter to 0, and the data-phase registers clear; HREADYOUT=1, HRESP=0, HRDATA=0 from the following cycle.
  - An in-flight write is dropped.
  - Memory contents are not reset.

Optional Feature:
- AHB_SRAM_SLAVE_ERR_EN.
- Defined: illegal accesses take the ERR1/ERR2 path as above.
- Undefined: illegal accesses follow the normal WAIT/LAST path with OKAY. Writes are suppressed, reads return 0, and ERR1/ERR2 are never entered.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS encodings (HTRANS_IDLE/BUSY/NONSEQ/SEQ);
  - HSIZE encodings (HSIZE_BYTE/HALF/WORD);
  - HRESP_OKAY/HRESP_ERROR;
  - the slave FSM state enum.
- Sub-module ahb_byte_strobe: combinational (HSIZE, HADDR[1:0]) → 4-bit strobe plus an aligned/legal flag. It is reusable by other slaves.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back → HREADYOUT stays 1; read data phase HRDATA=0xDEADBEEF; HRESP=0 throughout.
- WAIT_STATES=2: word read of 0x04 → HREADYOUT is 0,0,1 over the data phase, with HRDATA valid in the third cycle.
- Byte write 0xAA to 0x21 over prior word 0x11223344 at 0x20, then word read 0x20 → 0x1122AA44.
- Halfword write to 0x03 (misaligned), macro defined → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); memory unchanged. Macro undefined → OKAY, memory unchanged.
- MEM_DEPTH=256, word read at 0x400 (index 256) → ERROR pair with macro defined; NONSEQ presented during ERR2 to 0x0 is accepted and completes OKAY.
- HRESET asserted during WAIT of a write with WAIT_STATES=3 → next cycle HREADYOUT=1, HRESP=0, HRDATA=0, and the target word is unchanged on readback.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave FSM state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LAST,
        ST_ERR1,
        ST_ERR2
    } slave_state_e;

endpackage

// File: rtl/ahb_byte_strobe.sv
// Maps (HSIZE, HADDR[1:0]) to little-endian byte-lane strobes and an
// aligned/legal flag; strobes are zero for illegal combinations.
module ahb_byte_strobe
    import ahb_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] strb,
    output logic       legal
);

    always_comb begin
        strb  = '0;
        legal = 1'b0;
        case (hsize)
            HSIZE_BYTE: begin
                strb  = 4'b0001 << addr_lo;
                legal = 1'b1;
            end
            HSIZE_HALF: begin
                strb  = addr_lo[1] ? 4'b1100 : 4'b0011;
                legal = ~addr_lo[0];
            end
            HSIZE_WORD: begin
                strb  = 4'b1111;
                legal = (addr_lo == 2'b00);
            end
            default: ;
        endcase
        if (!legal)
            strb = '0;
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with programmable wait states and byte-lane writes.
// Define AHB_SRAM_SLAVE_ERR_EN to answer illegal accesses with a two-cycle ERROR.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DATA_W-1:0] HRDATA
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam logic [3:0]  WS = 4'(WAIT_STATES);
`ifdef AHB_SRAM_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    slave_state_e      state, state_nxt;
    logic [3:0]        cnt;
    logic [AW+1:0]     dp_addr;
    logic              dp_write;
    logic [2:0]        dp_size;
    logic              dp_illegal;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic        ap_legal, ap_illegal, accept, can_accept, xfer_req;
    logic [3:0]  ap_strb_unused;
    logic [3:0]  dp_strb;
    logic        dp_aligned, wr_en, rd_active;
    logic [AW-1:0] dp_idx;
    logic        addr_unused;

    ahb_byte_strobe u_ap_strobe (
        .hsize   (HSIZE),
        .addr_lo (HADDR[1:0]),
        .strb    (ap_strb_unused),
        .legal   (ap_legal)
    );

    ahb_byte_strobe u_dp_strobe (
        .hsize   (dp_size),
        .addr_lo (dp_addr[1:0]),
        .strb    (dp_strb),
        .legal   (dp_aligned)
    );

    assign addr_unused = ^HADDR[ADDR_W-1:AW+3];
    // Bit AW+2 of HADDR is the extra index bit: set means word index >= MEM_DEPTH.
    assign ap_illegal  = ~ap_legal | HADDR[AW+2];
    assign xfer_req    = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
    assign can_accept  = (state == ST_IDLE) || (state == ST_LAST) || (state == ST_ERR2);
    assign accept      = HSEL & HREADY & xfer_req & can_accept;
    assign dp_idx      = dp_addr[AW+1:2];
    assign wr_en       = (state == ST_LAST) & dp_write & ~dp_illegal & dp_aligned & ~HRESET;
    assign rd_active   = ((state == ST_WAIT) || (state == ST_LAST)) & ~dp_write & ~dp_illegal;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            dp_addr    <= '0;
            dp_write   <= 1'b0;
            dp_size    <= '0;
            dp_illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                dp_addr    <= HADDR[AW+1:0];
                dp_write   <= HWRITE;
                dp_size    <= HSIZE;
                dp_illegal <= ap_illegal;
                cnt        <= WS;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (dp_strb[i])
                    mem[dp_idx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state)
            ST_IDLE, ST_LAST, ST_ERR2: begin
                if (state == ST_ERR2)
                    HRESP = HRESP_ERROR;
                if (accept) begin
                    if (ap_illegal && ERR_EN)
                        state_nxt = ST_ERR1;
                    else if (WS == 4'd0)
                        state_nxt = ST_LAST;
                    else
                        state_nxt = ST_WAIT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (cnt <= 4'd1)
                    state_nxt = ST_LAST;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_nxt = ST_ERR2;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign HRDATA = rd_active ? mem[dp_idx] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench: three slaves (0, 2 and 3 wait states) on private buses,
// checked against an array-based model of the SRAM and the response rules.
module tb_ahb_sram_slave;
    import ahb_pkg::*;

`ifdef AHB_SRAM_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int ws_of [3] = '{0, 2, 3};

    logic clk = 1'b0;
    logic hreset = 1'b1;
    logic [2:0]       hsel, hwrite;
    logic [2:0][31:0] haddr, hwdata;
    logic [2:0][1:0]  htrans;
    logic [2:0][2:0]  hsize;
    wire  [2:0]       hreadyout, hresp;
    wire  [2:0][31:0] hrdata;

    logic [31:0] model [3][256];
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ahb_sram_slave #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]), .HREADY(hreadyout[0]),
        .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));

    ahb_sram_slave #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(256), .WAIT_STATES(2)) u_dut1 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]), .HREADY(hreadyout[1]),
        .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));

    ahb_sram_slave #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_dut2 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel[2]), .HADDR(haddr[2]), .HTRANS(htrans[2]),
        .HWRITE(hwrite[2]), .HSIZE(hsize[2]), .HWDATA(hwdata[2]), .HREADY(hreadyout[2]),
        .HREADYOUT(hreadyout[2]), .HRESP(hresp[2]), .HRDATA(hrdata[2]));

    function automatic bit legal(input logic [31:0] addr, input logic [2:0] size);
        int unsigned idx;
        idx = (addr >> 2) & 511;
        if (size > 3'd2) return 1'b0;
        if ((addr & ((32'd1 << size) - 32'd1)) != 0) return 1'b0;
        return idx < 256;
    endfunction

    function automatic void model_write(input int k, input logic [31:0] addr,
                                        input logic [2:0] size, input logic [31:0] wdata);
        int unsigned idx;
        int lane;
        idx = (addr >> 2) & 255;
        for (int b = 0; b < (1 << size); b++) begin
            lane = int'(addr & 3) + b;
            model[k][idx][lane*8 +: 8] = wdata[lane*8 +: 8];
        end
    endfunction

    task automatic idle_bus(input int k);
        hsel[k] = 1'b0; htrans[k] = HTRANS_IDLE; haddr[k] = '0;
        hwrite[k] = 1'b0; hsize[k] = HSIZE_WORD; hwdata[k] = '0;
    endtask

    // One non-pipelined transfer; starts and ends 1 time unit after a rising edge.
    task automatic xfer(input int k, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, output logic [31:0] rdata, output bit err,
                        output int lat);
        hsel[k] = 1'b1; htrans[k] = HTRANS_NONSEQ; haddr[k] = addr; hwrite[k] = wr; hsize[k] = size;
        @(posedge clk); #1;
        hsel[k] = 1'b0; htrans[k] = HTRANS_IDLE; hwdata[k] = wdata;
        err = 1'b0; lat = 0; rdata = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            lat++;
            if (hresp[k]) err = 1'b1;
            if (hreadyout[k]) begin
                rdata = hrdata[k];
                break;
            end
        end
        if (!hreadyout[k]) begin
            n_cmp++; n_fail++;
            $display("FAIL xfer_timeout dut%0d addr=%h: HREADYOUT still %b, required 1", k, addr, hreadyout[k]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        repeat (3) @(posedge clk);
        #1 hreset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (hreadyout[k] !== 1'b1) begin n_fail++; $display("FAIL reset_ready dut%0d: got %b, required 1", k, hreadyout[k]); end
            n_cmp++;
            if (hresp[k] !== 1'b0) begin n_fail++; $display("FAIL reset_resp dut%0d: got %b, required 0", k, hresp[k]); end
            n_cmp++;
            if (hrdata[k] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata dut%0d: got %h, required 0", k, hrdata[k]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        d = 32'hDEADBEEF;
        hsel[0] = 1'b1; htrans[0] = HTRANS_NONSEQ; haddr[0] = 32'h10; hwrite[0] = 1'b1; hsize[0] = HSIZE_WORD;
        @(negedge clk);
        n_cmp++;
        if (hreadyout[0] !== 1'b1 || hresp[0] !== 1'b0) begin
            n_fail++; $display("FAIL b2b_aphase: ready/resp %b/%b, required 1/0", hreadyout[0], hresp[0]);
        end
        @(posedge clk); #1;
        hwdata[0] = d; haddr[0] = 32'h10; hwrite[0] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (hreadyout[0] !== 1'b1 || hresp[0] !== 1'b0) begin
            n_fail++; $display("FAIL b2b_wdata: ready/resp %b/%b, required 1/0", hreadyout[0], hresp[0]);
        end
        @(posedge clk); #1;
        hsel[0] = 1'b0; htrans[0] = HTRANS_IDLE;
        model_write(0, 32'h10, HSIZE_WORD, d);
        @(negedge clk);
        n_cmp++;
        if (hreadyout[0] !== 1'b1 || hresp[0] !== 1'b0) begin
            n_fail++; $display("FAIL b2b_rphase: ready/resp %b/%b, required 1/0", hreadyout[0], hresp[0]);
        end
        n_cmp++;
        if (hrdata[0] !== model[0][4]) begin
            n_fail++; $display("FAIL b2b_rdata: got %h, required %h", hrdata[0], model[0][4]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wait_states();
        logic [31:0] v, r;
        bit e;
        int lat;
        v = $urandom;
        xfer(1, 1'b1, 32'h04, HSIZE_WORD, v, r, e, lat);
        model_write(1, 32'h04, HSIZE_WORD, v);
        n_cmp++;
        if (lat != 3) begin n_fail++; $display("FAIL ws2_write_latency: got %0d, required 3", lat); end
        hsel[1] = 1'b1; htrans[1] = HTRANS_NONSEQ; haddr[1] = 32'h04; hwrite[1] = 1'b0; hsize[1] = HSIZE_WORD;
        @(posedge clk); #1;
        idle_bus(1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (hreadyout[1] !== (c == 2) || hresp[1] !== 1'b0) begin
                n_fail++; $display("FAIL ws2_ready_c%0d: ready/resp %b/%b, required %b/0", c, hreadyout[1], hresp[1], c == 2);
            end
            if (c == 2) begin
                n_cmp++;
                if (hrdata[1] !== v) begin n_fail++; $display("FAIL ws2_rdata: got %h, required %h", hrdata[1], v); end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_byte_lanes();
        logic [31:0] r, w;
        bit e;
        int lat;
        for (int k = 0; k < 3; k++) begin
            xfer(k, 1'b1, 32'h20, HSIZE_WORD, 32'h11223344, r, e, lat);
            model_write(k, 32'h20, HSIZE_WORD, 32'h11223344);
            w = $urandom;
            w[15:8] = 8'hAA;
            xfer(k, 1'b1, 32'h21, HSIZE_BYTE, w, r, e, lat);
            model_write(k, 32'h21, HSIZE_BYTE, w);
            n_cmp++;
            if (e || lat != ws_of[k] + 1) begin
                n_fail++; $display("FAIL byte_write_resp dut%0d: err=%0d lat=%0d, required err=0 lat=%0d", k, e, lat, ws_of[k] + 1);
            end
            xfer(k, 1'b0, 32'h20, HSIZE_WORD, 32'h0, r, e, lat);
            n_cmp++;
            if (r !== 32'h1122AA44) begin n_fail++; $display("FAIL byte_lane dut%0d: got %h, required 1122aa44", k, r); end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] w, r;
        bit e, first_resp, first_ready;
        int lat, cyc;
        w = $urandom;
        xfer(0, 1'b1, 32'h00, HSIZE_WORD, w, r, e, lat);
        model_write(0, 32'h00, HSIZE_WORD, w);
        xfer(0, 1'b1, 32'h03, HSIZE_HALF, $urandom, r, e, lat);
        n_cmp++;
        if (e !== ERR_EN || lat != (ERR_EN ? 2 : 1)) begin
            n_fail++; $display("FAIL misaligned_resp: err=%0d lat=%0d, required err=%0d lat=%0d", e, lat, ERR_EN, ERR_EN ? 2 : 1);
        end
        hsel[0] = 1'b1; htrans[0] = HTRANS_NONSEQ; haddr[0] = 32'h400; hwrite[0] = 1'b0; hsize[0] = HSIZE_WORD;
        @(posedge clk); #1;
        idle_bus(0);
        @(negedge clk);
        cyc = 1; first_resp = hresp[0]; first_ready = hreadyout[0];
        while (!hreadyout[0] && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc != (ERR_EN ? 2 : 1) || first_resp !== ERR_EN || first_ready !== !ERR_EN) begin
            n_fail++; $display("FAIL oor_first: cycles=%0d resp=%b ready=%b, required %0d/%b/%b", cyc, first_resp, first_ready, ERR_EN ? 2 : 1, ERR_EN, !ERR_EN);
        end
        n_cmp++;
        if (hresp[0] !== ERR_EN || hrdata[0] !== 32'h0) begin
            n_fail++; $display("FAIL oor_last: resp=%b rdata=%h, required %b/0", hresp[0], hrdata[0], ERR_EN);
        end
        // Pipelined follow-up presented in the completing cycle of the bad transfer
        hsel[0] = 1'b1; htrans[0] = HTRANS_NONSEQ; haddr[0] = 32'h0; hwrite[0] = 1'b0; hsize[0] = HSIZE_WORD;
        @(posedge clk); #1;
        idle_bus(0);
        @(negedge clk);
        n_cmp++;
        if (hreadyout[0] !== 1'b1 || hresp[0] !== 1'b0 || hrdata[0] !== model[0][0]) begin
            n_fail++; $display("FAIL after_err_read: ready/resp/data %b/%b/%h, required 1/0/%h", hreadyout[0], hresp[0], hrdata[0], model[0][0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midwrite();
        logic [31:0] v, r;
        bit e;
        int lat;
        v = $urandom;
        xfer(2, 1'b1, 32'h30, HSIZE_WORD, v, r, e, lat);
        model_write(2, 32'h30, HSIZE_WORD, v);
        hsel[2] = 1'b1; htrans[2] = HTRANS_NONSEQ; haddr[2] = 32'h30; hwrite[2] = 1'b1; hsize[2] = HSIZE_WORD;
        @(posedge clk); #1;
        idle_bus(2);
        hwdata[2] = ~v;
        @(negedge clk);
        n_cmp++;
        if (hreadyout[2] !== 1'b0) begin n_fail++; $display("FAIL midwrite_wait: ready %b, required 0", hreadyout[2]); end
        hreset = 1'b1;
        @(posedge clk); #1;
        hreset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (hreadyout[2] !== 1'b1 || hresp[2] !== 1'b0 || hrdata[2] !== 32'h0) begin
            n_fail++; $display("FAIL midwrite_reset: ready/resp/data %b/%b/%h, required 1/0/0", hreadyout[2], hresp[2], hrdata[2]);
        end
        @(posedge clk); #1;
        xfer(2, 1'b0, 32'h30, HSIZE_WORD, 32'h0, r, e, lat);
        n_cmp++;
        if (r !== model[2][12]) begin n_fail++; $display("FAIL midwrite_dropped: got %h, required %h", r, model[2][12]); end
    endtask

    task automatic test_random();
        logic [31:0] addr, wd, r, exp_r;
        logic [2:0] size;
        bit wr, e, leg;
        int lat, exp_lat;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) begin
                wd = $urandom;
                xfer(k, 1'b1, 32'h100 + 32'(i * 4), HSIZE_WORD, wd, r, e, lat);
                model_write(k, 32'h100 + 32'(i * 4), HSIZE_WORD, wd);
            end
            for (int i = 0; i < 30; i++) begin
                wr = 1'($urandom_range(0, 1));
                size = 3'($urandom_range(0, 3));
                if (size == 3'd3) size = 3'($urandom_range(3, 7));
                addr = 32'h100 + 32'($urandom_range(0, 63));
                if ($urandom_range(0, 9) == 0) begin
                    addr = 32'h400 + 32'($urandom_range(0, 63) * 4);
                    size = HSIZE_WORD;
                end
                wd = $urandom;
                leg = legal(addr, size);
                xfer(k, wr, addr, size, wd, r, e, lat);
                exp_lat = (!leg && ERR_EN) ? 2 : ws_of[k] + 1;
                exp_r = leg ? model[k][(addr >> 2) & 255] : 32'h0;
                if (wr && leg) model_write(k, addr, size, wd);
                n_cmp++;
                if (lat != exp_lat || e !== (!leg && ERR_EN)) begin
                    n_fail++; $display("FAIL rand_resp dut%0d addr=%h size=%0d: lat=%0d err=%0d, required lat=%0d err=%0d", k, addr, size, lat, e, exp_lat, !leg && ERR_EN);
                end
                if (!wr) begin
                    n_cmp++;
                    if (r !== exp_r) begin
                        n_fail++; $display("FAIL rand_rdata dut%0d addr=%h size=%0d: got %h, required %h", k, addr, size, r, exp_r);
                    end
                end
            end
            for (int i = 0; i < 16; i++) begin
                xfer(k, 1'b0, 32'h100 + 32'(i * 4), HSIZE_WORD, 32'h0, r, e, lat);
                n_cmp++;
                if (r !== model[k][64 + i]) begin
                    n_fail++; $display("FAIL rand_sweep dut%0d word=%0d: got %h, required %h", k, 64 + i, r, model[k][64 + i]);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) idle_bus(k);
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_byte_lanes();
        test_illegal();
        test_reset_midwrite();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
